// File: rtl/path_stack_if.sv
// Interface for the path stack: controller commands, stack status and the replay stream.
interface path_stack_if;
  logic       push;
  logic       pop;
  logic       readFromStack;
  logic [7:0] dIn;
  logic       done;
  logic       empStck;
  logic [7:0] topLoc;
  logic       overflow;
  logic       showValid;
  logic       showReady;
  logic [7:0] showLoc;
  logic       showLast;
  logic       pathDone;

  modport master (
    output push, pop, readFromStack, dIn, done, showReady,
    input  empStck, topLoc, overflow, showValid, showLoc, showLast, pathDone
  );

  modport slave (
    input  push, pop, readFromStack, dIn, done, showReady,
    output empStck, topLoc, overflow, showValid, showLoc, showLast, pathDone
  );
endinterface

// File: rtl/path_stack.sv
// Location stack for the maze solver: push/pop/peek while searching, then a
// start-to-destination replay of the stored path over a valid/ready stream.
module path_stack #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  path_stack_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHOW, FIN} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   sp_reg;
  logic [AW-1:0] rd_ptr_reg;
  state_t        state_reg;
  logic [7:0]    top_loc_reg;
  logic          overflow_reg;
  logic          show_valid_reg;
  logic [7:0]    show_loc_reg;
  logic          show_last_reg;
  logic          path_done_reg;

  logic [AW:0]   sp_dec;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] rd_next;
  logic          nonempty;
  logic          full;
  logic          is_idle;
  logic          do_push;
  logic          do_pop;
  logic          replace_top;
  logic          append;
  logic          drop;
  logic          shrink;

  assign sp_dec   = sp_reg - ONE_CNT;
  assign top_idx  = sp_dec[AW-1:0];
  assign rd_next  = rd_ptr_reg + 1'b1;
  assign nonempty = (sp_reg != '0);
  assign full     = (sp_reg == FULL_CNT);
  assign is_idle  = (state_reg == IDLE);
  assign do_push  = is_idle & bus.push;
  assign do_pop   = is_idle & bus.pop;

  // Push+pop on a non-empty stack overwrites the top in place; on an empty
  // stack the pop has nothing to remove, so it degenerates to a plain push.
  assign replace_top = do_push & do_pop & nonempty;
  assign append      = do_push & ~(do_pop & nonempty) & ~full;
  assign drop        = do_push & ~(do_pop & nonempty) & full;
  assign shrink      = do_pop & ~do_push & nonempty;

  always_ff @(posedge clk) begin
    if (replace_top) begin
      mem[top_idx] <= bus.dIn;
    end else if (append) begin
      mem[sp_reg[AW-1:0]] <= bus.dIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      sp_reg         <= '0;
      rd_ptr_reg     <= '0;
      top_loc_reg    <= 8'h00;
      overflow_reg   <= 1'b0;
      show_valid_reg <= 1'b0;
      show_loc_reg   <= 8'h00;
      show_last_reg  <= 1'b0;
      path_done_reg  <= 1'b0;
    end else begin
      path_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (append) begin
            sp_reg <= sp_reg + ONE_CNT;
          end else if (shrink) begin
            sp_reg <= sp_dec;
          end
          if (drop) begin
            overflow_reg <= 1'b1;
          end
          // Peek uses the count as it stands this cycle, before any push/pop.
          if (bus.readFromStack) begin
            top_loc_reg <= nonempty ? mem[top_idx] : 8'h00;
          end
          if (bus.done) begin
            if (nonempty) begin
              rd_ptr_reg     <= '0;
              show_valid_reg <= 1'b1;
              show_loc_reg   <= mem[0];
              show_last_reg  <= (sp_reg == ONE_CNT);
              state_reg      <= SHOW;
            end else begin
              path_done_reg  <= 1'b1;
              state_reg      <= FIN;
            end
          end
        end
        SHOW: begin
          if (bus.showReady) begin
            if (show_last_reg) begin
              show_valid_reg <= 1'b0;
              show_loc_reg   <= 8'h00;
              show_last_reg  <= 1'b0;
              path_done_reg  <= 1'b1;
              state_reg      <= FIN;
            end else begin
              rd_ptr_reg    <= rd_next;
              show_loc_reg  <= mem[rd_next];
              show_last_reg <= ({1'b0, rd_next} == sp_dec);
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.empStck   = ~nonempty;
  assign bus.topLoc    = top_loc_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.showValid = show_valid_reg;
  assign bus.showLoc   = show_loc_reg;
  assign bus.showLast  = show_last_reg;
  assign bus.pathDone  = path_done_reg;

endmodule

// File: tb/tb_path_stack.sv
// Directed bench for path_stack: stack ops, replay with and without backpressure,
// reset during replay, overflow with a full 256-entry replay, empty replay.
module tb_path_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  path_stack_if bus();

  path_stack #(.DEPTH(256), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] v);
    bus.push = 1'b1; bus.dIn = v;
    step();
    bus.push = 1'b0;
  endtask

  task automatic pop_one();
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
  endtask

  task automatic read_top();
    bus.readFromStack = 1'b1;
    step();
    bus.readFromStack = 1'b0;
  endtask

  initial begin
    int beats;
    int cyc;
    bus.push = 1'b0; bus.pop = 1'b0; bus.readFromStack = 1'b0;
    bus.dIn = 8'h00; bus.done = 1'b0; bus.showReady = 1'b0;

    // Reset state
    step(); step();
    chk("rst_empStck",   32'(bus.empStck),   32'd1);
    chk("rst_topLoc",    32'(bus.topLoc),    32'h00);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_showValid", 32'(bus.showValid), 32'd0);
    chk("rst_showLoc",   32'(bus.showLoc),   32'h00);
    chk("rst_showLast",  32'(bus.showLast),  32'd0);
    chk("rst_pathDone",  32'(bus.pathDone),  32'd0);
    rst = 1'b0;
    step();

    // Basic push / peek / pop
    push_one(8'h00);
    chk("push1_empStck", 32'(bus.empStck), 32'd0);
    push_one(8'h01);
    push_one(8'h11);
    read_top();
    chk("read_top_11", 32'(bus.topLoc), 32'h11);
    pop_one();
    read_top();
    chk("read_top_01", 32'(bus.topLoc), 32'h01);
    pop_one();
    chk("pop2_empStck", 32'(bus.empStck), 32'd0);
    pop_one();
    chk("pop3_empStck", 32'(bus.empStck), 32'd1);
    pop_one();
    chk("extra_pop_empStck", 32'(bus.empStck), 32'd1);
    read_top();
    chk("read_empty_top", 32'(bus.topLoc), 32'h00);

    // Simultaneous push+pop replaces the top
    push_one(8'h10);
    bus.push = 1'b1; bus.pop = 1'b1; bus.dIn = 8'h20;
    step();
    bus.push = 1'b0; bus.pop = 1'b0;
    read_top();
    chk("replace_top", 32'(bus.topLoc), 32'h20);
    pop_one();
    chk("replace_sp1_empty", 32'(bus.empStck), 32'd1);

    // Three-entry replay at full throughput
    push_one(8'h00); push_one(8'h10); push_one(8'hFF);
    bus.showReady = 1'b1;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("r1_b0_valid", 32'(bus.showValid), 32'd1);
    chk("r1_b0_loc",   32'(bus.showLoc),   32'h00);
    chk("r1_b0_last",  32'(bus.showLast),  32'd0);
    step();
    chk("r1_b1_loc",   32'(bus.showLoc),   32'h10);
    chk("r1_b1_last",  32'(bus.showLast),  32'd0);
    step();
    chk("r1_b2_loc",   32'(bus.showLoc),   32'hFF);
    chk("r1_b2_last",  32'(bus.showLast),  32'd1);
    chk("r1_b2_pd",    32'(bus.pathDone),  32'd0);
    step();
    chk("r1_pathDone", 32'(bus.pathDone),  32'd1);
    chk("r1_fin_valid", 32'(bus.showValid), 32'd0);
    step();
    chk("r1_pd_pulse", 32'(bus.pathDone),  32'd0);
    chk("r1_nondestr", 32'(bus.empStck),   32'd0);

    // Same replay under backpressure, then reset mid-replay
    bus.showReady = 1'b0;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("r2_b0_loc",   32'(bus.showLoc),   32'h00);
    step();
    chk("r2_b0_hold",  32'(bus.showLoc),   32'h00);
    chk("r2_b0_hold_v", 32'(bus.showValid), 32'd1);
    bus.showReady = 1'b1;
    step();
    chk("r2_b1_loc",   32'(bus.showLoc),   32'h10);
    bus.showReady = 1'b0;
    step();
    chk("r2_b1_hold",  32'(bus.showLoc),   32'h10);
    bus.showReady = 1'b1;
    step();
    chk("r2_b2_loc",   32'(bus.showLoc),   32'hFF);
    chk("r2_b2_last",  32'(bus.showLast),  32'd1);
    rst = 1'b1;
    #1;
    chk("r2_rst_valid", 32'(bus.showValid), 32'd0);
    chk("r2_rst_empty", 32'(bus.empStck),   32'd1);
    step();
    rst = 1'b0;
    step(); step();
    chk("r2_after_pd",  32'(bus.pathDone),  32'd0);
    chk("r2_after_v",   32'(bus.showValid), 32'd0);

    // Fill past capacity, then replay all 256
    for (int i = 0; i < 256; i++) push_one(8'(i));
    chk("fill_no_ovf", 32'(bus.overflow), 32'd0);
    push_one(8'hAA);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    bus.showReady = 1'b1;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    beats = 0;
    cyc = 0;
    while (!bus.pathDone && cyc < 400) begin
      if (bus.showValid) begin
        chk($sformatf("full_loc_%0d", beats), 32'(bus.showLoc), 32'(beats & 8'hFF));
        chk($sformatf("full_last_%0d", beats), 32'(bus.showLast), 32'(beats == 255));
        beats++;
      end
      step();
      cyc++;
    end
    chk("full_pathDone", 32'(bus.pathDone), 32'd1);
    chk("full_beats",    32'(beats),        32'd256);
    chk("ovf_sticky",    32'(bus.overflow), 32'd1);

    // Replay with an empty stack
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("empty_pathDone", 32'(bus.pathDone),  32'd1);
    chk("empty_novalid",  32'(bus.showValid), 32'd0);
    step();
    chk("empty_pd_pulse", 32'(bus.pathDone),  32'd0);
    chk("empty_novalid2", 32'(bus.showValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
